// File: rtl/tile_plotter.sv
// Streams one TILE x TILE Othello cell glyph (corner markers or a disk) one pixel per cycle.
// Optional macro TILE_PLOTTER_BG_FILL_EN: out-of-shape pixels are plotted in BG_COLOR instead of skipped.
module tile_plotter #(
  parameter int                 TILE        = 12,
  parameter int                 X_W         = 8,
  parameter int                 Y_W         = 7,
  parameter int                 COLOR_W     = 3,
  parameter logic [COLOR_W-1:0] BG_COLOR    = 3'b010,
  parameter logic [COLOR_W-1:0] MARK_COLOR  = 3'b100,
  parameter logic [COLOR_W-1:0] BLACK_COLOR = 3'b000,
  parameter logic [COLOR_W-1:0] WHITE_COLOR = 3'b111,
  parameter int                 DISK_R2     = 160
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic [1:0]         select,
  input  logic               ready,
  output logic               busy,
  output logic               done,
  output logic               plot,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] color,
  output logic [1:0]         dbg_state_o
);

  localparam int CW = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int AW = 2 * $clog2(TILE) + 3;
  localparam int SW = 2 * AW;
  localparam logic [CW-1:0] LAST = CW'(TILE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [X_W-1:0]     x_lat_q;
  logic [Y_W-1:0]     y_lat_q;
  logic [1:0]         sel_q;
  logic [CW-1:0]      dx_q, dy_q;
  logic               busy_q, done_q, plot_q;
  logic [X_W-1:0]     x_out_q;
  logic [Y_W-1:0]     y_out_q;
  logic [COLOR_W-1:0] color_q;

  logic [CW-1:0]      dx_d, dy_d;
  logic [X_W-1:0]     org_x;
  logic [Y_W-1:0]     org_y;
  logic [1:0]         nsel;
  logic signed [SW-1:0] a, b, r2;
  logic               corner, hit;
  logic [COLOR_W-1:0] shape_col;
  logic               plot_d;
  logic [X_W-1:0]     x_out_d;
  logic [Y_W-1:0]     y_out_d;
  logic [COLOR_W-1:0] color_d;
  logic               advance, last_px;

  // plot is the valid strobe; a plotted pixel is consumed on a cycle where plot && ready,
  // an unplotted pixel is consumed every cycle regardless of ready.
  assign advance = (state_q == S_DRAW) && (!plot_q || ready);
  assign last_px = (dx_q == LAST) && (dy_q == LAST);

  // Next pixel to present: (0,0) of a fresh request in IDLE, otherwise the row-major successor.
  always_comb begin
    dx_d  = '0;
    dy_d  = '0;
    org_x = x_in;
    org_y = y_in;
    nsel  = select;
    if (state_q != S_IDLE) begin
      org_x = x_lat_q;
      org_y = y_lat_q;
      nsel  = sel_q;
      if (dx_q == LAST) begin
        dx_d = '0;
        dy_d = dy_q + 1'b1;
      end else begin
        dx_d = dx_q + 1'b1;
        dy_d = dy_q;
      end
    end

    a  = $signed(SW'({dx_d, 1'b0})) - $signed(SW'(TILE - 1));
    b  = $signed(SW'({dy_d, 1'b0})) - $signed(SW'(TILE - 1));
    r2 = a * a + b * b;
    corner = ((dx_d == '0) || (dx_d == LAST)) && ((dy_d == '0) || (dy_d == LAST));

    if (nsel[1]) begin
      hit       = (r2 <= $signed(SW'(DISK_R2)));
      shape_col = nsel[0] ? WHITE_COLOR : BLACK_COLOR;
    end else begin
      hit       = corner;
      shape_col = nsel[0] ? MARK_COLOR : BG_COLOR;
    end

`ifdef TILE_PLOTTER_BG_FILL_EN
    plot_d = 1'b1;
`else
    plot_d = hit;
`endif
    color_d = hit ? shape_col : BG_COLOR;
    x_out_d = org_x + X_W'(dx_d);
    y_out_d = org_y + Y_W'(dy_d);
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q <= S_IDLE;
      x_lat_q <= '0;
      y_lat_q <= '0;
      sel_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      plot_q  <= 1'b0;
      x_out_q <= '0;
      y_out_q <= '0;
      color_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          plot_q <= 1'b0;
          if (start) begin
            x_lat_q <= x_in;
            y_lat_q <= y_in;
            sel_q   <= select;
            dx_q    <= '0;
            dy_q    <= '0;
            busy_q  <= 1'b1;
            plot_q  <= plot_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            color_q <= color_d;
            state_q <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (advance) begin
            if (last_px) begin
              busy_q  <= 1'b0;
              plot_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              dx_q    <= dx_d;
              dy_q    <= dy_d;
              plot_q  <= plot_d;
              x_out_q <= x_out_d;
              y_out_q <= y_out_d;
              color_q <= color_d;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          plot_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign plot        = plot_q;
  assign x_out       = x_out_q;
  assign y_out       = y_out_q;
  assign color       = color_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tile_plotter.sv
// Scoreboard bench for tile_plotter: expected pixels queued at request time, popped on each accepted plot.
// Honours TILE_PLOTTER_BG_FILL_EN when the build defines it.
module tb_tile_plotter;
  localparam int T = 12;
  localparam int PW = 1 + 8 + 7 + 3;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [1:0] select;
  logic       ready;
  logic       busy, done, plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] color;
  logic [1:0] dbg_state;

  tile_plotter dut (
    .clock(clock), .resetn(resetn), .start(start), .x_in(x_in), .y_in(y_in),
    .select(select), .ready(ready), .busy(busy), .done(done), .plot(plot),
    .x_out(x_out), .y_out(y_out), .color(color), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference glyph model
  task automatic model_px(input int dx, input int dy, input logic [1:0] sel,
                          output logic hit, output logic [2:0] col);
    int a, b;
    if (sel[1]) begin
      a   = 2 * dx - (T - 1);
      b   = 2 * dy - (T - 1);
      hit = (a * a + b * b) <= 160;
      col = sel[0] ? 3'b111 : 3'b000;
    end else begin
      hit = (dx == 0 || dx == T - 1) && (dy == 0 || dy == T - 1);
      col = sel[0] ? 3'b100 : 3'b010;
    end
    if (!hit) col = 3'b010;
  endtask

  // scoreboard
  logic [PW-2:0] exp_q[$];
  int exp_plots, plot_cnt, draw_cyc, stall_cyc, done_cnt;
  int ready_mode = 0;
  logic hold_pend = 1'b0;
  logic [PW-1:0] hold_val;

  task automatic push_expected(input logic [7:0] x, input logic [6:0] y, input logic [1:0] sel);
    logic hit;
    logic [2:0] col;
    logic [7:0] px;
    logic [6:0] py;
    for (int dy = 0; dy < T; dy++) begin
      for (int dx = 0; dx < T; dx++) begin
        model_px(dx, dy, sel, hit, col);
        px = x + 8'(dx);
        py = y + 7'(dy);
`ifdef TILE_PLOTTER_BG_FILL_EN
        exp_q.push_back({px, py, col});
`else
        if (hit) exp_q.push_back({px, py, col});
`endif
      end
    end
    exp_plots = exp_q.size();
  endtask

  // ready driver: always high, or toggled every 3 cycles
  initial begin
    int ph;
    ph = 0;
    ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (ready_mode == 0) ready = 1'b1;
      else begin
        ph++;
        if (ph == 3) begin
          ph = 0;
          ready = ~ready;
        end
      end
    end
  end

  // monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (resetn) hold_pend = 1'b0;
    else begin
      if (hold_pend) check("hold_while_stalled", {plot, x_out, y_out, color}, hold_val);
      hold_pend = plot && !ready;
      hold_val  = {plot, x_out, y_out, color};
      if (busy) draw_cyc++;
      if (plot && !ready) stall_cyc++;
      if (done) done_cnt++;
      if (plot && ready) begin
        plot_cnt++;
        check("sb_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("pixel", {x_out, y_out, color}, exp_q.pop_front());
      end
    end
  end

  task automatic clear_counters();
    plot_cnt = 0; draw_cyc = 0; stall_cyc = 0; done_cnt = 0;
  endtask

  task automatic run_draw(input logic [7:0] x, input logic [6:0] y, input logic [1:0] sel,
                          input int rmode, input bit inject);
    logic hit;
    logic [2:0] col;
    bit got_done;
    int n;
    exp_q.delete();
    push_expected(x, y, sel);
    @(posedge clock);
    #1;
    clear_counters();
    ready_mode = rmode;
    start = 1'b1; x_in = x; y_in = y; select = sel;
    @(posedge clock);
    #1;
    start = 1'b0;
    x_in = 8'($urandom_range(0, 255)); y_in = 7'($urandom_range(0, 127));
    select = 2'($urandom_range(0, 3));
    model_px(0, 0, sel, hit, col);
`ifdef TILE_PLOTTER_BG_FILL_EN
    hit = 1'b1;
`endif
    check("first_busy", busy, 1);
    check("first_state", dbg_state, 2'd1);
    check("first_x", x_out, x);
    check("first_y", y_out, y);
    check("first_plot", plot, hit);
    got_done = 0;
    n = 0;
    while (!got_done && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
      start = 1'b0;
      if (inject && n == 20) start = 1'b1;
      if (done) begin
        got_done = 1;
        if (inject) start = 1'b1;
      end
    end
    check("done_seen", got_done, 1);
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    ready_mode = 0;
    check("busy_after", busy, 0);
    check("done_count", done_cnt, 1);
    check("plot_count", plot_cnt, exp_plots);
    check("sb_drained", exp_q.size(), 0);
    check("draw_cycles", draw_cyc, T * T + stall_cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b1; start = 1'b0; x_in = '0; y_in = '0; select = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {busy, done, plot, x_out, y_out, color}, 0);
    check("reset_state", dbg_state, 2'd0);
    resetn = 1'b0;

    // disk: 3+2+1 pixels cut from each corner leaves 120 plotted
    run_draw(8'd20, 7'd30, 2'd2, 0, 0);
`ifndef TILE_PLOTTER_BG_FILL_EN
    check("disk_plots", plot_cnt, 120);
`endif
    run_draw(8'd60, 7'd40, 2'd1, 0, 0);
    run_draw(8'd60, 7'd40, 2'd0, 0, 0);
    run_draw(8'd100, 7'd20, 2'd3, 1, 0);
    run_draw(8'd250, 7'd125, 2'd3, 0, 0);
    run_draw(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)),
             2'($urandom_range(0, 3)), 1, 0);

    // abort a draw at pixel 50 with reset
    exp_q.delete();
    push_expected(8'd40, 7'd50, 2'd2);
    @(posedge clock);
    #1;
    clear_counters();
    start = 1'b1; x_in = 8'd40; y_in = 7'd50; select = 2'd2;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (50) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check("midreset_outputs", {busy, done, plot, x_out, y_out, color}, 0);
    check("midreset_state", dbg_state, 2'd0);
    exp_q.delete();
    done_cnt = 0;
    @(posedge clock);
    #1;
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("aborted_no_done", done_cnt, 0);
    check("aborted_idle", busy, 0);
    run_draw(8'd5, 7'd7, 2'd2, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
